// File: rtl/input_process_spi_pkg.sv
// Shared constants for the SPI receive path: default word width, receive FSM
// encoding and error-counter width.
package input_process_spi_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [0:0] RX_HUNT  = 1'b0;
  localparam logic [0:0] RX_SHIFT = 1'b1;

endpackage

// File: rtl/in_fifo_spi.sv
// Synchronous word FIFO with synchronous clear, registered fill count and
// full/empty flags. Read data is the head word, valid whenever not empty.
module in_fifo_spi #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      fill_q;
  logic             rd_ok, wr_ok;

  assign full  = (fill_q == DepthCnt);
  assign empty = (fill_q == '0);
  assign fill  = fill_q;

  // A write into a full FIFO is accepted only when the head leaves this same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = mem_q[rptr_q];

  always_ff @(posedge CLK) begin
    if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/input_process_spi.sv
// SPI receive path: deserializes a strobe-framed bit stream into words, buffers
// them in a FIFO and hands them to the consumer with flow control and error count.
module input_process_spi
  import input_process_spi_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STOP_MARGIN = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_DATA,
  input  logic                 RX_VALID,
  input  logic                 RX_LOAD,
  input  logic                 HOLD,
  output logic [WIDTH-1:0]     DATA,
  output logic                 ENA,
  output logic                 RX_STOP,
  output logic                 FRAME_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [1:0]           state_mon
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
  localparam logic [AW:0]   StopThr = (AW + 1)'(DEPTH - STOP_MARGIN);

  logic [0:0]           rx_state_q, rx_state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic                 wr_q, wr_d;
  logic [WIDTH-1:0]     wr_word_q, wr_word_d;
  logic                 shift_err;

  logic [WIDTH-1:0]     data_q;
  logic                 ena_q, rx_stop_q, ferr_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic [WIDTH-1:0]     fifo_rdata;
  logic [AW:0]          fifo_fill;
  logic                 fifo_full, fifo_empty;
  logic                 pop, drop, err_evt;

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    wr_d       = 1'b0;
    wr_word_d  = wr_word_q;
    shift_err  = 1'b0;
    if (RX_VALID) begin
      if (rx_state_q == RX_HUNT) begin
        if (RX_LOAD) begin
          rx_state_d = RX_SHIFT;
          cnt_d      = '0;
        end
      end else begin
        sr_d = {sr_q[WIDTH-2:0], RX_DATA};
        if (RX_LOAD) begin
          // A strobe always resyncs the bit counter; only a full-length word is kept.
          cnt_d = '0;
          if (cnt_q == CntLast) begin
            wr_d      = 1'b1;
            wr_word_d = sr_d;
          end else begin
            shift_err = 1'b1;
          end
        end else if (cnt_q == CntLast) begin
          shift_err  = 1'b1;
          cnt_d      = '0;
          rx_state_d = RX_HUNT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  assign pop     = !fifo_empty && !HOLD;
  assign drop    = wr_q && fifo_full && !pop;
  assign err_evt = shift_err || drop;

  in_fifo_spi #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .clr     (RST),
    .wr_en   (wr_q && !drop),
    .wr_data (wr_word_q),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .fill    (fifo_fill),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state_q <= RX_HUNT;
      cnt_q      <= '0;
      sr_q       <= '0;
      wr_q       <= 1'b0;
      wr_word_q  <= '0;
      data_q     <= '0;
      ena_q      <= 1'b0;
      rx_stop_q  <= 1'b0;
      ferr_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      wr_q       <= wr_d;
      wr_word_q  <= wr_word_d;
      ena_q      <= pop;
      if (pop) data_q <= fifo_rdata;
      rx_stop_q  <= (fifo_fill >= StopThr);
      ferr_q     <= err_evt;
      if (err_evt && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign DATA      = data_q;
  assign ENA       = ena_q;
  assign RX_STOP   = rx_stop_q;
  assign FRAME_ERR = ferr_q;
  assign ERR_CNT   = err_cnt_q;
  assign state_mon = {fifo_empty, rx_state_q};

endmodule

// File: tb/tb_input_process_spi.sv
// Bench for input_process_spi: scenario tasks with randomized stimulus checked
// against word lists and cycle expectations derived from the receive rules.
module tb_input_process_spi;
  localparam int unsigned W = 16;

  logic          CLK = 1'b0;
  logic          RST, RX_DATA, RX_VALID, RX_LOAD, HOLD;
  logic [W-1:0]  DATA;
  logic          ENA, RX_STOP, FRAME_ERR;
  logic [7:0]    ERR_CNT;
  logic [1:0]    state_mon;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_edge = 0;
  int hold_pct = 0;
  int err_pulses = 0;
  int last_err_cyc = -1;
  logic [W-1:0] got_q[$];
  int ena_cyc_q[$];

  input_process_spi dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_LOAD   (RX_LOAD),
    .HOLD      (HOLD),
    .DATA      (DATA),
    .ENA       (ENA),
    .RX_STOP   (RX_STOP),
    .FRAME_ERR (FRAME_ERR),
    .ERR_CNT   (ERR_CNT),
    .state_mon (state_mon)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // cyc read here equals the index of the rising edge that produced the outputs.
  always @(negedge CLK) begin
    if (ENA === 1'b1) begin
      got_q.push_back(DATA);
      ena_cyc_q.push_back(cyc);
    end
    if (FRAME_ERR === 1'b1) begin
      err_pulses++;
      last_err_cyc = cyc;
    end
  end

  task automatic drive_hold();
    if (hold_pct > 0) HOLD = 1'($urandom_range(99) < hold_pct);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_VALID = 1'b0;
      RX_DATA  = 1'($urandom_range(1));
      RX_LOAD  = 1'($urandom_range(1));
      drive_hold();
    end
  endtask

  task automatic send_bit(input logic d, input logic ld);
    @(negedge CLK);
    RX_VALID  = 1'b1;
    RX_DATA   = d;
    RX_LOAD   = ld;
    drive_hold();
    last_edge = cyc + 1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap_pct);
    for (int i = W - 1; i >= 0; i--) begin
      while ($urandom_range(99) < gap_pct) idle(1);
      send_bit(w[i], 1'(i == 0));
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1; RX_VALID = 1'b0; RX_LOAD = 1'b0; RX_DATA = 1'b0; HOLD = 1'b0; hold_pct = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (DATA !== 16'h0) $display("FAIL reset_data got=%h exp=0", DATA); else passed++;
    checks++; if (ENA !== 1'b0) $display("FAIL reset_ena got=%b exp=0", ENA); else passed++;
    checks++; if (RX_STOP !== 1'b0) $display("FAIL reset_rx_stop got=%b exp=0", RX_STOP); else passed++;
    checks++; if (FRAME_ERR !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", FRAME_ERR); else passed++;
    checks++; if (ERR_CNT !== 8'd0) $display("FAIL reset_errcnt got=%0d exp=0", ERR_CNT); else passed++;
    checks++; if (state_mon !== 2'b10) $display("FAIL reset_state got=%b exp=10", state_mon); else passed++;
  endtask

  task automatic test_basic();
    int g0 = got_q.size();
    int lb;
    send_bit(1'b1, 1'b1);
    send_word(16'hA5C3, 0);
    lb = last_edge;
    idle(5);
    checks++; if (got_q.size() - g0 != 1) $display("FAIL basic_count got=%0d exp=1", got_q.size() - g0); else passed++;
    checks++; if (got_q[g0] !== 16'hA5C3) $display("FAIL basic_data got=%h exp=a5c3", got_q[g0]); else passed++;
    checks++; if (ena_cyc_q[g0] - lb != 2) $display("FAIL basic_latency got=%0d exp=2", ena_cyc_q[g0] - lb); else passed++;
    checks++; if (DATA !== 16'hA5C3) $display("FAIL basic_data_hold got=%h exp=a5c3", DATA); else passed++;
    checks++; if (ENA !== 1'b0) $display("FAIL basic_ena_pulse got=%b exp=0", ENA); else passed++;
  endtask

  task automatic test_short_word();
    int e0 = err_pulses;
    int g0 = got_q.size();
    int lb;
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(1)), 1'(i == 9));
    lb = last_edge;
    idle(2);
    checks++; if (err_pulses - e0 != 1) $display("FAIL short_err_pulses got=%0d exp=1", err_pulses - e0); else passed++;
    checks++; if (last_err_cyc != lb) $display("FAIL short_err_timing got=%0d exp=%0d", last_err_cyc, lb); else passed++;
    send_word(16'h1234, 0);
    idle(5);
    checks++; if (got_q.size() - g0 != 1) $display("FAIL short_count got=%0d exp=1", got_q.size() - g0); else passed++;
    checks++; if (got_q[g0] !== 16'h1234) $display("FAIL short_data got=%h exp=1234", got_q[g0]); else passed++;
    checks++; if (ERR_CNT !== 8'd1) $display("FAIL short_errcnt got=%0d exp=1", ERR_CNT); else passed++;
  endtask

  task automatic test_long_word();
    int e0 = err_pulses;
    int g0;
    int lb;
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(1)), 1'b0);
    lb = last_edge;
    idle(2);
    checks++; if (err_pulses - e0 != 1) $display("FAIL long_err_pulses got=%0d exp=1", err_pulses - e0); else passed++;
    checks++; if (last_err_cyc != lb) $display("FAIL long_err_timing got=%0d exp=%0d", last_err_cyc, lb); else passed++;
    checks++; if (state_mon[0] !== 1'b0) $display("FAIL long_hunt got=%b exp=0", state_mon[0]); else passed++;
    g0 = got_q.size();
    // Bits in HUNT are ignored; the word's final strobe acts as the new sync.
    send_word(16'hBEEF, 0);
    idle(5);
    checks++; if (got_q.size() != g0) $display("FAIL long_ignored got=%0d exp=0", got_q.size() - g0); else passed++;
    checks++; if (ERR_CNT !== 8'd2) $display("FAIL long_errcnt got=%0d exp=2", ERR_CNT); else passed++;
    checks++; if (state_mon[0] !== 1'b1) $display("FAIL long_resync got=%b exp=1", state_mon[0]); else passed++;
    send_word(16'h0F0F, 0);
    idle(5);
    checks++; if (got_q[g0] !== 16'h0F0F) $display("FAIL long_after_sync got=%h exp=0f0f", got_q[g0]); else passed++;
  endtask

  task automatic test_overflow();
    logic [W-1:0] words [17];
    int e0 = err_pulses;
    int g0 = got_q.size();
    int fall = -1;
    int bad_order = 0;
    int bad_b2b = 0;
    @(negedge CLK);
    HOLD = 1'b1;
    for (int i = 0; i < 17; i++) begin
      words[i] = 16'($urandom);
      send_word(words[i], 0);
      idle(3);
      if (i < 16) begin
        checks++;
        if (RX_STOP !== 1'(i + 1 >= 12))
          $display("FAIL ovf_rx_stop_after_%0d got=%b exp=%b", i + 1, RX_STOP, (i + 1 >= 12));
        else passed++;
      end
    end
    checks++; if (got_q.size() != g0) $display("FAIL ovf_hold got=%0d exp=0", got_q.size() - g0); else passed++;
    checks++; if (err_pulses - e0 != 1) $display("FAIL ovf_drop_err got=%0d exp=1", err_pulses - e0); else passed++;
    checks++; if (ERR_CNT !== 8'd3) $display("FAIL ovf_errcnt got=%0d exp=3", ERR_CNT); else passed++;
    @(negedge CLK);
    HOLD = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (RX_STOP === 1'b0 && fall < 0) fall = cyc;
    end
    checks++; if (got_q.size() - g0 != 16) $display("FAIL ovf_drain_count got=%0d exp=16", got_q.size() - g0); else passed++;
    for (int i = 0; i < 16; i++) begin
      if (got_q[g0 + i] !== words[i]) bad_order++;
      if (ena_cyc_q[g0 + i] != ena_cyc_q[g0] + i) bad_b2b++;
    end
    checks++; if (bad_order != 0) $display("FAIL ovf_order got=%0d_bad exp=0", bad_order); else passed++;
    checks++; if (bad_b2b != 0) $display("FAIL ovf_back_to_back got=%0d_bad exp=0", bad_b2b); else passed++;
    // Fill reaches 11 after the fifth pop; the registered flag follows one edge later.
    checks++;
    if (fall - ena_cyc_q[g0] != 5) $display("FAIL ovf_stop_fall got=%0d exp=5", fall - ena_cyc_q[g0]);
    else passed++;
    checks++; if (state_mon[1] !== 1'b1) $display("FAIL ovf_empty got=%b exp=1", state_mon[1]); else passed++;
  endtask

  task automatic test_rst_mid_word();
    int g0;
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(1)), 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    RX_VALID = 1'b0;
    checks++; if (DATA !== 16'h0) $display("FAIL rst_mid_data got=%h exp=0", DATA); else passed++;
    checks++; if (ERR_CNT !== 8'd0) $display("FAIL rst_mid_errcnt got=%0d exp=0", ERR_CNT); else passed++;
    checks++; if (RX_STOP !== 1'b0 || ENA !== 1'b0 || FRAME_ERR !== 1'b0)
      $display("FAIL rst_mid_flags got=%b%b%b exp=000", RX_STOP, ENA, FRAME_ERR); else passed++;
    checks++; if (state_mon !== 2'b10) $display("FAIL rst_mid_state got=%b exp=10", state_mon); else passed++;
    g0 = got_q.size();
    send_word(16'h55AA, 0);
    idle(5);
    checks++; if (got_q.size() != g0) $display("FAIL rst_mid_nosync got=%0d exp=0", got_q.size() - g0); else passed++;
    checks++; if (state_mon !== 2'b11) $display("FAIL rst_mid_resync got=%b exp=11", state_mon); else passed++;
  endtask

  task automatic test_random_gaps();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w;
    int g0;
    int e0;
    int bad = 0;
    apply_reset();
    g0 = got_q.size();
    e0 = err_pulses;
    hold_pct = 30;
    send_bit(1'b1, 1'b1);
    for (int n = 0; n < 100; n++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      send_word(w, 50);
    end
    idle(10);
    hold_pct = 0;
    HOLD = 1'b0;
    idle(30);
    checks++; if (got_q.size() - g0 != 100) $display("FAIL rand_count got=%0d exp=100", got_q.size() - g0); else passed++;
    for (int i = 0; i < 100; i++) if (got_q[g0 + i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) $display("FAIL rand_data got=%0d_bad exp=0", bad); else passed++;
    checks++; if (ERR_CNT !== 8'd0) $display("FAIL rand_errcnt got=%0d exp=0", ERR_CNT); else passed++;
    checks++; if (err_pulses != e0) $display("FAIL rand_err_pulses got=%0d exp=0", err_pulses - e0); else passed++;
  endtask

  initial begin
    RST = 1'b1; RX_DATA = 1'b0; RX_VALID = 1'b0; RX_LOAD = 1'b0; HOLD = 1'b0;
    test_reset();
    test_basic();
    test_short_word();
    test_long_word();
    test_overflow();
    test_rst_mid_word();
    test_random_gaps();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=no_finish exp=finish");
    $fatal(1);
  end

endmodule
